div_frac: RTL

- Sequential unsigned fixed-point divider. Computes the fraction Out = A/B in [0,1] for operands in the same SIZE-bit format.
- It is the inverse of the team's fraction multiplier: it produces the B-operand fraction that multiplier consumes, e.g. normalised weights and blend ratios.
- Uses restoring division, one quotient bit per clock, with a Start/Busy/Done handshake.
- Sits between integer accumulators and the fraction-multiply datapath.

---
 rtl/div_frac.sv | 121 ++++++++++++
 1 files changed

// File: rtl/div_frac.sv
// Sequential restoring divider producing the fraction A/B with FRAC fractional bits.
// One quotient bit per clock; A >= B clamps to 1.0, B == 0 flags Div_zero.
module div_frac #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned FRAC = SIZE / 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic [SIZE-1:0] Out,
    output logic            Busy,
    output logic            Done,
    output logic            Sat,
    output logic            Div_zero
);

    localparam int unsigned KW = $clog2(SIZE);
    localparam logic [SIZE-1:0] ONE = SIZE'(1) << FRAC;

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e          state_q, state_d;
    logic [SIZE:0]   r_q, r_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            done_q, done_d;
    logic            sat_q, sat_d;
    logic            dz_q, dz_d;
    logic [SIZE:0]   t;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            k_q     <= k_d;
            b_q     <= b_d;
            out_q   <= out_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        k_d     = k_q;
        b_d     = b_q;
        out_d   = out_q;
        sat_d   = sat_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        t       = '0;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    b_d = B;
                    if (B == '0) begin
                        out_d  = ONE;
                        dz_d   = 1'b1;
                        sat_d  = 1'b0;
                        done_d = 1'b1;
                    end else if (A >= B) begin
                        out_d  = ONE;
                        sat_d  = 1'b1;
                        dz_d   = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        r_d     = {1'b0, A};
                        q_d     = '0;
                        k_d     = KW'(FRAC - 1);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // R < B always holds here, so the shift cannot lose the top bit.
                t = r_q << 1;
                if (t >= {1'b0, b_q}) begin
                    r_d = t - {1'b0, b_q};
                    q_d = {q_q[SIZE-2:0], 1'b1};
                end else begin
                    r_d = t;
                    q_d = {q_q[SIZE-2:0], 1'b0};
                end
                k_d = k_q - 1'b1;
                if (k_q == '0) begin
                    out_d   = q_d;
                    sat_d   = 1'b0;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Out      = out_q;
    assign Busy     = (state_q == StCalc);
    assign Done     = done_q;
    assign Sat      = sat_q;
    assign Div_zero = dz_q;

endmodule
